// File: rtl/psram_responder.sv
// Device-side PSRAM responder: decodes SPI init commands and QPI read/write bursts
// against an internal 16-bit word array. Requires 4 <= ADDR_BITS <= 24.
module psram_responder #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 6
) (
    input  logic       mem_clk,
    input  logic       rst_n,
    input  logic       mem_ce,
    input  logic [3:0] sio_in,
    output logic [3:0] sio_out,
    output logic       sio_oe,
    output logic       qpi_mode,
    output logic       cmd_error,
    output logic [7:0] last_cmd
);

    typedef enum logic [2:0] {
        IDLE,
        SPI_CMD,
        QPI_CMD,
        QPI_ADDR,
        WR_DATA,
        RD_WAIT,
        RD_DATA,
        IGNORE
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [6:0]             shreg_q, shreg_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [11:0]            wdata_q, wdata_d;
    logic [3:0]             sioOut_q, sioOut_d;
    logic                   sioOe_q, sioOe_d;
    logic                   qpi_q, qpi_d;
    logic                   err_q, err_d;
    logic [7:0]             last_q, last_d;
    logic                   armed_q, armed_d;

    logic [15:0]            mem [2**ADDR_BITS];
    logic                   memWe;
    logic [15:0]            memWdata;
    logic [15:0]            rdWord;

    logic [7:0]             spiByte;
    logic [7:0]             qpiByte;
    logic [7:0]             cmdByte;
    logic                   cmdDone;

    assign spiByte  = {shreg_q, sio_in[0]};
    assign qpiByte  = {shreg_q[3:0], sio_in};
    assign cmdByte  = (state_q == QPI_CMD) ? qpiByte : spiByte;
    assign cmdDone  = !mem_ce && ((state_q == SPI_CMD && cnt_q == 4'd7) || state_q == QPI_CMD);
    assign rdWord   = mem[addr_q];
    assign memWdata = {wdata_q, sio_in};

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Deselect wins over every transition; otherwise each state advances on its own count.
    always_comb begin
        state_d = state_q;
        if (mem_ce) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:     state_d = qpi_q ? QPI_CMD : SPI_CMD;
                SPI_CMD:  if (cnt_q == 4'd7) state_d = IGNORE;
                QPI_CMD:  state_d = (qpiByte == 8'hEB || qpiByte == 8'h02) ? QPI_ADDR : IGNORE;
                QPI_ADDR: if (cnt_q == 4'd5) state_d = (last_q == 8'h02) ? WR_DATA : RD_WAIT;
                RD_WAIT:  if (cnt_q == 4'(WAIT_CYCLES)) state_d = RD_DATA;
                WR_DATA, RD_DATA, IGNORE: state_d = state_q;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        sioOut_d = sioOut_q;
        sioOe_d  = 1'b0;
        qpi_d    = qpi_q;
        err_d    = 1'b0;
        last_d   = last_q;
        armed_d  = armed_q;
        memWe    = 1'b0;

        if (cmdDone) begin
            last_d  = cmdByte;
            armed_d = (cmdByte == 8'h66);
            case (cmdByte)
                8'h66: ;
                8'h99: if (armed_q) qpi_d = 1'b0; else err_d = 1'b1;
                8'h35: if (state_q == SPI_CMD) qpi_d = 1'b1; else err_d = 1'b1;
                8'hEB, 8'h02: if (state_q == SPI_CMD) err_d = 1'b1;
                default: err_d = 1'b1;
            endcase
        end

        if (mem_ce) begin
            cnt_d = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    shreg_d = qpi_q ? {3'b0, sio_in} : {6'b0, sio_in[0]};
                    cnt_d   = 4'd1;
                end
                SPI_CMD: begin
                    shreg_d = spiByte[6:0];
                    cnt_d   = (cnt_q == 4'd7) ? 4'd0 : cnt_q + 4'd1;
                end
                QPI_CMD: cnt_d = 4'd0;
                QPI_ADDR: begin
                    addr_d = {addr_q[ADDR_BITS-5:0], sio_in};
                    if (cnt_q == 4'd5) begin
                        cnt_d = (last_q == 8'h02) ? 4'd0 : 4'd1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                WR_DATA: begin
                    wdata_d = {wdata_q[7:0], sio_in};
                    if (cnt_q == 4'd3) begin
                        memWe  = 1'b1;
                        addr_d = addr_q + 1'b1;
                        cnt_d  = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == 4'(WAIT_CYCLES)) begin
                        sioOe_d  = 1'b1;
                        sioOut_d = rdWord[15:12];
                        cnt_d    = 4'd1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                RD_DATA: begin
                    sioOe_d = 1'b1;
                    case (cnt_q[1:0])
                        2'd0:    sioOut_d = rdWord[15:12];
                        2'd1:    sioOut_d = rdWord[11:8];
                        2'd2:    sioOut_d = rdWord[7:4];
                        default: sioOut_d = rdWord[3:0];
                    endcase
                    // Address advances after the last nibble so the next edge starts the next word.
                    if (cnt_q[1:0] == 2'd3) begin
                        addr_d = addr_q + 1'b1;
                        cnt_d  = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 4'd0;
            shreg_q  <= 7'd0;
            addr_q   <= '0;
            wdata_q  <= 12'd0;
            sioOut_q <= 4'd0;
            sioOe_q  <= 1'b0;
            qpi_q    <= 1'b0;
            err_q    <= 1'b0;
            last_q   <= 8'd0;
            armed_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            sioOut_q <= sioOut_d;
            sioOe_q  <= sioOe_d;
            qpi_q    <= qpi_d;
            err_q    <= err_d;
            last_q   <= last_d;
            armed_q  <= armed_d;
        end
    end

    // Array is deliberately not reset; contents survive rst_n.
    always_ff @(posedge mem_clk) begin
        if (memWe) begin
            mem[addr_q] <= memWdata;
        end
    end

    assign sio_out   = sioOut_q;
    assign sio_oe    = sioOe_q;
    assign qpi_mode  = qpi_q;
    assign cmd_error = err_q;
    assign last_cmd  = last_q;

endmodule

// File: tb/tb_psram_responder.sv
// Directed self-checking bench for psram_responder: SPI init commands, QPI
// write/read bursts, address wrap, partial-write discard and async reset.
module tb_psram_responder;

    localparam int ADDR_BITS   = 8;
    localparam int WAIT_CYCLES = 6;

    logic       mem_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic       mem_ce  = 1'b1;
    logic [3:0] sio_in  = 4'd0;
    logic [3:0] sio_out;
    logic       sio_oe;
    logic       qpi_mode;
    logic       cmd_error;
    logic [7:0] last_cmd;

    int checks = 0;
    int errors = 0;

    psram_responder #(
        .ADDR_BITS  (ADDR_BITS),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .mem_clk  (mem_clk),
        .rst_n    (rst_n),
        .mem_ce   (mem_ce),
        .sio_in   (sio_in),
        .sio_out  (sio_out),
        .sio_oe   (sio_oe),
        .qpi_mode (qpi_mode),
        .cmd_error(cmd_error),
        .last_cmd (last_cmd)
    );

    always #5 mem_clk = ~mem_clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are looked at 1 time unit after the rising edge.
    task automatic applyStimulus(input logic ce, input logic [3:0] d);
        @(negedge mem_clk);
        mem_ce = ce;
        sio_in = d;
        @(posedge mem_clk);
        #1;
    endtask

    task automatic deselect();
        applyStimulus(1'b1, 4'd0);
    endtask

    task automatic spiByte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) applyStimulus(1'b0, {3'b0, b[i]});
    endtask

    task automatic qpiByte(input logic [7:0] b);
        applyStimulus(1'b0, b[7:4]);
        applyStimulus(1'b0, b[3:0]);
    endtask

    task automatic qpiAddr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) applyStimulus(1'b0, a[i*4 +: 4]);
    endtask

    task automatic qpiWord(input logic [15:0] w);
        for (int i = 3; i >= 0; i--) applyStimulus(1'b0, w[i*4 +: 4]);
    endtask

    task automatic writeWords(input logic [23:0] a, input int n, input logic [15:0] w0, input logic [15:0] w1);
        qpiByte(8'h02);
        qpiAddr(a);
        qpiWord(w0);
        if (n > 1) qpiWord(w1);
        deselect();
    endtask

    task automatic readWords(input string tag, input logic [23:0] a, input int n,
                             input logic [15:0] w0, input logic [15:0] w1);
        logic [15:0] word;
        qpiByte(8'hEB);
        qpiAddr(a);
        for (int k = 1; k < WAIT_CYCLES; k++) begin
            applyStimulus(1'b0, 4'd0);
            checkOutput({tag, "_wait_oe"}, 16'(sio_oe), 16'd0);
        end
        for (int w = 0; w < n; w++) begin
            word = (w == 0) ? w0 : w1;
            for (int i = 3; i >= 0; i--) begin
                applyStimulus(1'b0, 4'd0);
                checkOutput({tag, "_oe"}, 16'(sio_oe), 16'd1);
                checkOutput({tag, "_nib"}, 16'(sio_out), 16'(word[i*4 +: 4]));
            end
        end
        deselect();
        checkOutput({tag, "_deselect_oe"}, 16'(sio_oe), 16'd0);
    endtask

    initial begin
        #12;
        checkOutput("rst_sio_out", 16'(sio_out), 16'd0);
        checkOutput("rst_sio_oe", 16'(sio_oe), 16'd0);
        checkOutput("rst_qpi", 16'(qpi_mode), 16'd0);
        checkOutput("rst_err", 16'(cmd_error), 16'd0);
        checkOutput("rst_last", 16'(last_cmd), 16'd0);
        @(negedge mem_clk);
        rst_n = 1'b1;
        deselect();

        spiByte(8'h99);
        checkOutput("rst_unarmed_err", 16'(cmd_error), 16'd1);
        checkOutput("rst_unarmed_qpi", 16'(qpi_mode), 16'd0);
        checkOutput("rst_unarmed_last", 16'(last_cmd), 16'h99);
        deselect();
        checkOutput("err_pulse_end", 16'(cmd_error), 16'd0);

        spiByte(8'h66);
        checkOutput("rsten_err", 16'(cmd_error), 16'd0);
        deselect();
        spiByte(8'h12);
        checkOutput("bad_op_err", 16'(cmd_error), 16'd1);
        checkOutput("bad_op_last", 16'(last_cmd), 16'h12);
        deselect();
        spiByte(8'h99);
        checkOutput("disarmed_err", 16'(cmd_error), 16'd1);
        deselect();

        spiByte(8'h66);
        deselect();
        spiByte(8'h99);
        checkOutput("rst_ok_err", 16'(cmd_error), 16'd0);
        checkOutput("rst_ok_qpi", 16'(qpi_mode), 16'd0);
        deselect();
        spiByte(8'h35);
        checkOutput("enter_qpi_err", 16'(cmd_error), 16'd0);
        checkOutput("enter_qpi", 16'(qpi_mode), 16'd1);
        checkOutput("enter_qpi_last", 16'(last_cmd), 16'h35);
        deselect();

        writeWords(24'h000010, 1, 16'hABCD, 16'h0000);
        readWords("rd10", 24'h000010, 1, 16'hABCD, 16'h0000);
        readWords("rd10_upper", 24'h123410, 1, 16'hABCD, 16'h0000);

        writeWords(24'h0000FF, 2, 16'h1111, 16'h2222);
        readWords("rd00_wrap", 24'h000000, 1, 16'h2222, 16'h0000);
        readWords("rdFF_burst", 24'h0000FF, 2, 16'h1111, 16'h2222);

        writeWords(24'h000005, 1, 16'h1234, 16'h0000);
        qpiByte(8'h02);
        qpiAddr(24'h000005);
        applyStimulus(1'b0, 4'h9);
        applyStimulus(1'b0, 4'h9);
        deselect();
        readWords("rd05_partial", 24'h000005, 1, 16'h1234, 16'h0000);

        qpiByte(8'h35);
        checkOutput("qpi_bad_op_err", 16'(cmd_error), 16'd1);
        checkOutput("qpi_bad_op_mode", 16'(qpi_mode), 16'd1);
        deselect();

        // Async reset while data nibbles are being driven.
        qpiByte(8'hEB);
        qpiAddr(24'h000010);
        for (int k = 1; k < WAIT_CYCLES; k++) applyStimulus(1'b0, 4'd0);
        applyStimulus(1'b0, 4'd0);
        checkOutput("pre_rst_nib", 16'(sio_out), 16'hA);
        applyStimulus(1'b0, 4'd0);
        checkOutput("pre_rst_oe", 16'(sio_oe), 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_oe", 16'(sio_oe), 16'd0);
        checkOutput("async_rst_qpi", 16'(qpi_mode), 16'd0);
        checkOutput("async_rst_out", 16'(sio_out), 16'd0);
        checkOutput("async_rst_last", 16'(last_cmd), 16'd0);
        @(negedge mem_clk);
        mem_ce = 1'b1;
        rst_n  = 1'b1;
        deselect();
        spiByte(8'hEB);
        checkOutput("post_rst_spi_err", 16'(cmd_error), 16'd1);
        checkOutput("post_rst_spi_last", 16'(last_cmd), 16'hEB);
        checkOutput("post_rst_spi_qpi", 16'(qpi_mode), 16'd0);
        deselect();

        spiByte(8'h35);
        deselect();
        qpiByte(8'h66);
        checkOutput("qpi_rsten_err", 16'(cmd_error), 16'd0);
        deselect();
        qpiByte(8'h99);
        checkOutput("qpi_rst_err", 16'(cmd_error), 16'd0);
        checkOutput("qpi_rst_mode", 16'(qpi_mode), 16'd0);
        deselect();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
